// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, control code type, alignment state.
package tmds_pkg;

    localparam int unsigned SYMBOL_W = 10;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CTRL_W   = 2;

    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        ALIGN_SEARCH    = 2'd0,
        ALIGN_SLIP_WAIT = 2'd1,
        ALIGN_LOCKED    = 2'd2
    } tmds_align_state_t;

    // One decoded symbol as carried between pipeline stages.
    typedef struct packed {
        logic              is_ctrl;
        ctrl_t             ctrl;
        logic [DATA_W-1:0] data;
    } tmds_sym_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS 10b->8b symbol decode: control token detect plus data recovery.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYMBOL_W-1:0] symbol,
    output logic                is_ctrl_c,
    output logic [CTRL_W-1:0]   ctrl_c,
    output logic [DATA_W-1:0]   data_c
);

    logic [DATA_W-1:0] d;

    always_comb begin
        is_ctrl_c = 1'b1;
        ctrl_c    = 2'b00;
        case (symbol)
            CTRL_TOKEN_00: ctrl_c = 2'b00;
            CTRL_TOKEN_01: ctrl_c = 2'b01;
            CTRL_TOKEN_10: ctrl_c = 2'b10;
            CTRL_TOKEN_11: ctrl_c = 2'b11;
            default:       is_ctrl_c = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain selected by bit 8.
    always_comb begin
        d         = symbol[9] ? ~symbol[7:0] : symbol[7:0];
        data_c    = '0;
        data_c[0] = d[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            data_c[i] = symbol[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive decoder with word-alignment FSM driving deserializer bitslip.
// Optional TMDS_DECODER_ERR_CNT_EN adds err_count (saturating lock-loss count).
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned ALIGN_TOKENS = 8,
    parameter int unsigned SEARCH_LIMIT = 4096,
    parameter int unsigned SLIP_WAIT    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        symbol_valid,
    input  logic [9:0]  symbol,
    output logic        out_valid,
    output logic [7:0]  data,
    output logic        de,
    output logic [1:0]  ctrl,
    output logic        locked,
    output logic        bitslip
`ifdef TMDS_DECODER_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned TOK_W  = $clog2(ALIGN_TOKENS + 1);
    localparam int unsigned CNT_W  = $clog2(SEARCH_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    tmds_sym_t          dec_c;
    tmds_sym_t          s1_sym;
    logic               s1_valid;

    tmds_align_state_t  state_q, state_d;
    logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               locked_d, bitslip_d, lock_lost_c;

    tmds_symbol_decode u_decode (
        .symbol    (symbol),
        .is_ctrl_c (dec_c.is_ctrl),
        .ctrl_c    (dec_c.ctrl),
        .data_c    (dec_c.data)
    );

    // Stage 1: capture qualifier and decoded symbol.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sym   <= '0;
        end else begin
            s1_valid <= symbol_valid;
            if (symbol_valid) begin
                s1_sym <= dec_c;
            end
        end
    end

    // Stage 2: outputs; data holds across control tokens, ctrl holds across data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            data      <= '0;
            de        <= 1'b0;
            ctrl      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                de <= ~s1_sym.is_ctrl;
                if (s1_sym.is_ctrl) begin
                    ctrl <= s1_sym.ctrl;
                end else begin
                    data <= s1_sym.data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ALIGN_SEARCH;
            tok_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tok_cnt_q  <= tok_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // sym_cnt doubles as the token-free gap counter while locked.
    always_comb begin
        state_d    = state_q;
        tok_cnt_d  = tok_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ALIGN_SEARCH: begin
                if (s1_valid) begin
                    tok_cnt_d = s1_sym.is_ctrl ? tok_cnt_q + TOK_W'(1) : '0;
                    sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    if (tok_cnt_d == TOK_W'(ALIGN_TOKENS)) begin
                        state_d   = ALIGN_LOCKED;
                        tok_cnt_d = '0;
                        sym_cnt_d = '0;
                    end else if (sym_cnt_d == CNT_W'(SEARCH_LIMIT)) begin
                        state_d    = ALIGN_SLIP_WAIT;
                        tok_cnt_d  = '0;
                        sym_cnt_d  = '0;
                        wait_cnt_d = '0;
                    end
                end
            end
            ALIGN_SLIP_WAIT: begin
                if (wait_cnt_q == WAIT_W'(SLIP_WAIT)) begin
                    state_d    = ALIGN_SEARCH;
                    wait_cnt_d = '0;
                    tok_cnt_d  = '0;
                    sym_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ALIGN_LOCKED: begin
                if (s1_valid) begin
                    sym_cnt_d = s1_sym.is_ctrl ? '0 : sym_cnt_q + CNT_W'(1);
                    if (sym_cnt_d == CNT_W'(SEARCH_LIMIT)) begin
                        state_d   = ALIGN_SEARCH;
                        sym_cnt_d = '0;
                        tok_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d    = ALIGN_SEARCH;
                tok_cnt_d  = '0;
                sym_cnt_d  = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        locked_d    = (state_d == ALIGN_LOCKED);
        bitslip_d   = (state_q == ALIGN_SEARCH) && (state_d == ALIGN_SLIP_WAIT);
        lock_lost_c = (state_q == ALIGN_LOCKED) && (state_d == ALIGN_SEARCH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked  <= 1'b0;
            bitslip <= 1'b0;
        end else begin
            locked  <= locked_d;
            bitslip <= bitslip_d;
        end
    end

`ifdef TMDS_DECODER_ERR_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (lock_lost_c && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost_c;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: reference TMDS encoder, delayed-output model, slip-timing checks.
module tb_tmds_decoder;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam int SLIP_PERIOD = 4096 + 16 + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       symbol_valid = 1'b0;
    logic [9:0] symbol = '0;
    logic       out_valid, de, locked, bitslip;
    logic [7:0] data;
    logic [1:0] ctrl;
`ifdef TMDS_DECODER_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    tmds_decoder dut (
        .clock        (clock),
        .reset        (reset),
        .symbol_valid (symbol_valid),
        .symbol       (symbol),
        .out_valid    (out_valid),
        .data         (data),
        .de           (de),
        .ctrl         (ctrl),
        .locked       (locked),
        .bitslip      (bitslip)
`ifdef TMDS_DECODER_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: previous input, expected held outputs, slip bookkeeping.
    logic       pv = 1'b0, pknown = 1'b0;
    int         pcode = -1;
    logic [7:0] pbyte = '0;
    logic       exp_de = 1'b0, data_known = 1'b1;
    logic [1:0] exp_ctrl = '0;
    logic [7:0] exp_data = '0;
    logic       prev_bs = 1'b0;
    int         cyc = 0;
    int         slips = 0;
    int         slip_cyc[$];
    int         disp = 0;
    int         rot = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            T00:     return 0;
            T01:     return 1;
            T10:     return 2;
            T11:     return 3;
            default: return -1;
        endcase
    endfunction

    // DVI transmitter encoding with running disparity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] b);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, ones, zeros;
        n1 = $countones(b);
        qm[0] = b[0];
        if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (disp == 0 || ones == zeros) begin
            q[9]   = ~qm[8];
            q[8]   = qm[8];
            q[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
            disp   = qm[8] ? disp + ones - zeros : disp + zeros - ones;
        end else if ((disp > 0 && ones > zeros) || (disp < 0 && zeros > ones)) begin
            q      = {1'b1, qm[8], ~qm[7:0]};
            disp   = disp + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            q      = {1'b0, qm[8], qm[7:0]};
            disp   = disp - 2 * int'(!qm[8]) + ones - zeros;
        end
        return q;
    endfunction

    // Window of the repeated token stream, shifted r bits relative to word alignment.
    function automatic logic [9:0] rot_word(input logic [9:0] t, input int r);
        logic [9:0] o;
        for (int i = 0; i < 10; i++) o[i] = t[(i + r) % 10];
        return o;
    endfunction

    // One clock: drive inputs, then compare outputs with the input from the previous cycle.
    task automatic step(input logic v, input logic [9:0] w, input logic known, input logic [7:0] b);
        symbol_valid = v;
        symbol       = w;
        @(posedge clock);
        #1;
        cyc++;
        if (reset) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_data", data, 0);
            check_eq("rst_de", de, 0);
            check_eq("rst_ctrl", ctrl, 0);
            check_eq("rst_locked", locked, 0);
            check_eq("rst_bitslip", bitslip, 0);
            pv = 1'b0; exp_de = 1'b0; exp_ctrl = '0; exp_data = '0; data_known = 1'b1;
        end else begin
            if (pv) begin
                if (pcode >= 0) begin
                    exp_de   = 1'b0;
                    exp_ctrl = 2'(pcode);
                end else begin
                    exp_de = 1'b1;
                    if (pknown) begin
                        exp_data   = pbyte;
                        data_known = 1'b1;
                    end else begin
                        data_known = 1'b0;
                    end
                end
            end
            check_eq("out_valid", out_valid, pv);
            check_eq("de", de, exp_de);
            check_eq("ctrl", ctrl, exp_ctrl);
            if (data_known) check_eq("data", data, exp_data);
            if (bitslip) begin
                check_eq("bitslip_width", prev_bs, 0);
                slips++;
                slip_cyc.push_back(cyc);
            end
            pv = v; pcode = tok_code(w); pknown = known; pbyte = b;
        end
        prev_bs = bitslip;
    endtask

    task automatic send_byte(input logic [7:0] b);
        step(1'b1, tmds_encode(b), 1'b1, b);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        reset = 1'b0;
        slips = 0;
        slip_cyc.delete();
    endtask

    // Rotated token stream; the bench's deserializer model slips one bit per pulse.
    task automatic run_rotation(input int rot0, input int exp_slips);
        int c0, n, budget;
        pulse_reset();
        c0 = cyc;
        rot = rot0;
        n = 0;
        budget = exp_slips * SLIP_PERIOD + 4200;
        while (!locked && n < budget) begin
            step(1'b1, rot_word(T00, rot), 1'b0, '0);
            if (bitslip) rot = (rot + 9) % 10;
            n++;
        end
        check_eq("rot_lock", locked, 1);
        check_eq("rot_slips", slips, exp_slips);
        if (slip_cyc.size() > 0) check_eq("first_slip", slip_cyc[0] - c0, 4097);
        for (int k = 1; k < slip_cyc.size(); k++)
            check_eq("slip_spacing", slip_cyc[k] - slip_cyc[k-1], SLIP_PERIOD);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dir_bytes [4];
        int c0, n;
        dir_bytes[0] = 8'h00; dir_bytes[1] = 8'hFF; dir_bytes[2] = 8'h55; dir_bytes[3] = 8'hA3;

        repeat (3) step(1'b0, '0, 1'b0, '0);
        reset = 1'b0;

        // Lock on the 8th token, then a different token.
        for (int j = 0; j < 11; j++) begin
            if (j < 8)       step(1'b1, T00, 1'b0, '0);
            else if (j == 8) step(1'b1, T01, 1'b0, '0);
            else             step(1'b0, '0, 1'b0, '0);
            if (j >= 1 && j <= 9) check_eq("lock_on_8th", locked, (j >= 8));
        end
        check_eq("ctrl_last", ctrl, 2'b01);
        check_eq("de_ctrl", de, 0);

        // Locked data: directed bytes then random, with periodic tokens.
        foreach (dir_bytes[i]) send_byte(dir_bytes[i]);
        step(1'b0, '0, 1'b0, '0);
        check_eq("dir_data_a3", data, 8'hA3);
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 49) step(1'b1, T10, 1'b0, '0);
            else              send_byte(8'($urandom));
        end
        step(1'b1, T11, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        check_eq("still_locked", locked, 1);

        // Lock loss after 4096 token-free symbols.
`ifdef TMDS_DECODER_ERR_CNT_EN
        check_eq("err_count_0", err_count, 0);
`endif
        for (int i = 0; i < 4097; i++) begin
            if (i < 4096) send_byte(8'($urandom));
            else          step(1'b0, '0, 1'b0, '0);
            if (i == 4095) check_eq("lock_hold_4095", locked, 1);
            if (i == 4096) check_eq("lock_drop_4096", locked, 0);
        end
`ifdef TMDS_DECODER_ERR_CNT_EN
        check_eq("err_count_1", err_count, 1);
`endif

        // Alternating valid: lock after 8 valid tokens, outputs hold on gaps.
        pulse_reset();
        for (int j = 0; j < 17; j++) begin
            if (j % 2 == 0 && j < 16) step(1'b1, T00, 1'b0, '0);
            else                      step(1'b0, 10'($urandom), 1'b0, '0);
            if (j == 14) check_eq("gap_no_lock", locked, 0);
            if (j == 15) check_eq("gap_lock", locked, 1);
        end

        run_rotation(3, 3);
        run_rotation(7, 7);

        // Reset asserted during SLIP_WAIT.
        pulse_reset();
        rot = 3;
        n = 0;
        while (slips == 0 && n < 4200) begin
            step(1'b1, rot_word(T00, rot), 1'b0, '0);
            n++;
        end
        check_eq("pre_reset_slip", slips, 1);
        repeat (5) step(1'b1, rot_word(T00, rot), 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_out_valid", out_valid, 0);
        check_eq("async_de", de, 0);
        check_eq("async_data", data, 0);
        check_eq("async_locked", locked, 0);
        check_eq("async_bitslip", bitslip, 0);
        repeat (2) step(1'b0, '0, 1'b0, '0);
        reset = 1'b0;
        slips = 0;
        slip_cyc.delete();
        c0 = cyc;
        n = 0;
        while (slips == 0 && n < 4200) begin
            step(1'b1, rot_word(T00, rot), 1'b0, '0);
            n++;
        end
        check_eq("restart_slip_seen", slips, 1);
        if (slip_cyc.size() > 0) check_eq("restart_slip_time", slip_cyc[0] - c0, 4097);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
